jtag_avalon_stream_bridge: RTL

//  Parametrised Avalon-MM master for the JTAG UART IP: polls data/control regs, buffers bytes in RX/TX FIFOs
//  and exposes valid/ready byte streams to dsa_jtag_interface. Adds burst RX drain (RAVAIL), cached WSPACE
//  for back-to-back TX writes, RX/TX fairness, idle-poll throttling and a waitrequest timeout.

---
 rtl/jtag_av_pkg.sv | 20 ++
 rtl/byte_sync_fifo.sv | 56 +++++
 rtl/jtag_avalon_stream_bridge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_av_pkg.sv
// Shared types and register-map constants for the JTAG UART Avalon-MM stream bridge.
package jtag_av_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdData,
    StRdCtrl,
    StWrData,
    StBackoff
  } state_t;

  // JTAG UART register fields
  localparam int unsigned RVALID_BIT = 15;
  localparam int unsigned AVAIL_MSB  = 31;
  localparam int unsigned AVAIL_LSB  = 16;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

endpackage

// File: rtl/byte_sync_fifo.sv
// Single-clock FIFO with combinational head read and occupancy output.
module byte_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push;
  logic             do_pop;

  // Overflow/underflow are blocked here, so the level saturates by construction.
  assign full    = (count_q == (AddrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = count_q;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/jtag_avalon_stream_bridge.sv
// Avalon-MM master polling a JTAG UART and presenting RX/TX byte streams.
module jtag_avalon_stream_bridge
  import jtag_av_pkg::*;
#(
  parameter int unsigned RX_DEPTH     = 16,
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned POLL_IDLE    = 8,
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        av_chipselect,
  output logic                        av_address,
  output logic                        av_read_n,
  output logic                        av_write_n,
  input  logic [31:0]                 av_readdata,
  output logic [31:0]                 av_writedata,
  input  logic                        av_waitrequest,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic                        err_timeout
);

  localparam int unsigned RxLw  = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TxLw  = $clog2(TX_DEPTH) + 1;
  localparam int unsigned WaitW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam int unsigned BoW   = (POLL_IDLE < 2) ? 1 : $clog2(POLL_IDLE + 1);

  localparam logic [WaitW-1:0] WaitLast   = WaitW'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);
  localparam logic [BoW-1:0]   BoLoad     = BoW'(POLL_IDLE);
  localparam logic [RxLw-1:0]  RxLastFree = RxLw'(RX_DEPTH - 1);

  state_t           state_q, state_d;
  logic             read_n_q, read_n_d;
  logic             write_n_q, write_n_d;
  logic             addr_q, addr_d;
  logic             err_q, err_d;
  logic             last_tx_q, last_tx_d;
  logic [15:0]      cache_q, cache_d;
  logic [BoW-1:0]   backoff_q, backoff_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_head;
  logic        rx_elig, tx_elig, grant_rx, grant_tx;
  logic        access, accept, timeout_hit, rvalid, burst, more_tx;
  logic [15:0] ravail;
  logic        unused_rd;

  byte_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (av_readdata[7:0]),
    .pop   (rx_pop),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  byte_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (tx_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_ready & ~rx_empty;
  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & ~tx_full;

  assign av_chipselect = 1'b1;
  assign av_address    = addr_q;
  assign av_read_n     = read_n_q;
  assign av_write_n    = write_n_q;
  assign err_timeout   = err_q;
  // TX head is stable throughout a write since only this block pops it.
  assign av_writedata  = (state_q == StWrData) ? {24'd0, tx_head} : 32'd0;

  assign rvalid    = av_readdata[RVALID_BIT];
  assign ravail    = av_readdata[AVAIL_MSB:AVAIL_LSB];
  assign unused_rd = ^av_readdata[14:8];

  // Arbitration: a tie goes to whichever side was not granted last.
  assign rx_elig  = ~rx_full && (backoff_q == '0);
  assign tx_elig  = ~tx_empty;
  assign grant_rx = rx_elig & (~tx_elig | last_tx_q);
  assign grant_tx = tx_elig & (~rx_elig | ~last_tx_q);

  assign access      = (state_q == StRdData) || (state_q == StRdCtrl) || (state_q == StWrData);
  assign accept      = access & ~av_waitrequest;
  assign timeout_hit = (WAIT_TIMEOUT != 0) && access && av_waitrequest && (wait_q == WaitLast);
  // Burst only while another byte is pending and a slot remains after this push.
  assign burst       = (ravail != 16'd0) && (rx_level < RxLastFree);
  assign more_tx     = (tx_level > TxLw'(1)) && (cache_q > 16'd1);

  // State register plus registered strobes and bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      addr_q    <= ADDR_DATA;
      err_q     <= 1'b0;
      last_tx_q <= 1'b1;
      cache_q   <= '0;
      backoff_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      read_n_q  <= read_n_d;
      write_n_q <= write_n_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      last_tx_q <= last_tx_d;
      cache_q   <= cache_d;
      backoff_q <= backoff_d;
      wait_q    <= wait_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant_rx)      state_d = StRdData;
        else if (grant_tx) state_d = (cache_q == '0) ? StRdCtrl : StWrData;
      end
      StRdData: begin
        if (timeout_hit) state_d = StIdle;
        else if (accept) begin
          if (rvalid)              state_d = burst ? StRdData : StIdle;
          else if (POLL_IDLE != 0) state_d = StBackoff;
          else                     state_d = StIdle;
        end
      end
      StRdCtrl: begin
        if (timeout_hit) state_d = StIdle;
        else if (accept) state_d = (ravail != 16'd0) ? StWrData : StIdle;
      end
      StWrData: begin
        if (timeout_hit) state_d = StIdle;
        else if (accept) state_d = more_tx ? StWrData : StIdle;
      end
      StBackoff: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Strobes follow the next state; FIFO controls and counters follow the current one.
  always_comb begin
    read_n_d  = ~((state_d == StRdData) || (state_d == StRdCtrl));
    write_n_d = ~(state_d == StWrData);
    addr_d    = (state_d == StRdCtrl) ? ADDR_CTRL : ADDR_DATA;
    err_d     = timeout_hit;
    rx_push   = 1'b0;
    tx_pop    = 1'b0;
    last_tx_d = last_tx_q;
    cache_d   = cache_q;
    backoff_d = backoff_q;
    wait_d    = '0;
    if (backoff_q != '0) backoff_d = backoff_q - 1'b1;
    if ((WAIT_TIMEOUT != 0) && access && av_waitrequest && !timeout_hit) wait_d = wait_q + 1'b1;
    // Forget the cached space on abort so the retry re-reads WSPACE.
    if (timeout_hit) cache_d = '0;
    case (state_q)
      StIdle: begin
        if (grant_rx)      last_tx_d = 1'b0;
        else if (grant_tx) last_tx_d = 1'b1;
      end
      StRdData: begin
        if (accept) begin
          if (rvalid) rx_push = 1'b1;
          else        backoff_d = BoLoad;
        end
      end
      StRdCtrl: begin
        if (accept) cache_d = ravail;
      end
      StWrData: begin
        if (accept) begin
          tx_pop  = 1'b1;
          cache_d = cache_q - 16'd1;
        end
      end
      default: ;
    endcase
  end

endmodule
